// File: rtl/root_seq_if.sv
// Operand/result handshakes plus the shared external adder port for root_seq.
// master = producer/consumer/adder side, slave = the root engine.
// Widths follow the engine parameters; instantiate with the same WIDTH.
interface root_seq_if #(
   parameter int WIDTH = 8,
   parameter int RW    = (WIDTH + 1) / 2,
   parameter int AW    = WIDTH + 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x_i;
   logic             mode_i;
   logic             out_valid;
   logic             out_ready;
   logic [RW-1:0]    root_o;
   logic [WIDTH-1:0] rem_o;
   logic             busy;
   logic [AW-1:0]    sum_a;
   logic [AW-1:0]    sum_b;
   logic             sum_cin;
   logic [AW-1:0]    sum_out;
   logic             sum_cout;

   modport master (
      output in_valid, x_i, mode_i, out_ready, sum_out, sum_cout,
      input  in_ready, out_valid, root_o, rem_o, busy, sum_a, sum_b, sum_cin
   );

   modport slave (
      input  in_valid, x_i, mode_i, out_ready, sum_out, sum_cout,
      output in_ready, out_valid, root_o, rem_o, busy, sum_a, sum_b, sum_cin
   );
endinterface

// File: rtl/root_seq.sv
// Sequential floor cube root (mode 0) / square root (mode 1) with remainder.
// Latency accept->out_valid: cube 6*ITC+1, sqrt 2*ITS+1 cycles.
// Accepts only in IDLE; result held until out_ready, in_valid while busy is dropped.
module root_seq #(
   parameter int WIDTH = 8,
   parameter int RW    = (WIDTH + 1) / 2,
   parameter int AW    = WIDTH + 4
) (
   input logic clk,
   input logic rst,
   root_seq_if.slave io
);
   localparam int ITC = (WIDTH + 2) / 3;
   localparam int ITS = (WIDTH + 1) / 2;
   localparam int SW  = $clog2(3 * ITC + 1);
   localparam logic [AW-1:0] ONE = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_DBL, S_C3Q, S_C3Y2, S_C3Y1, S_CMP, S_QUPD, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    x_q, x_d;      // running remainder
   logic [AW-1:0]    y_q, y_d;      // partial root
   logic [AW-1:0]    q_q, q_d;      // y^2, cube path only
   logic [AW-1:0]    acc_q, acc_d;  // 3q+3y+1 under construction
   logic [SW-1:0]    s_q, s_d;      // bit position of current digit
   logic             mode_q, mode_d;
   logic             take_q, take_d;
   logic             out_valid_q, out_valid_d;
   logic [RW-1:0]    root_q, root_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [AW-1:0]    sum_a, sum_b;
   logic             sum_cin;

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         q_q         <= '0;
         acc_q       <= '0;
         s_q         <= '0;
         mode_q      <= 1'b0;
         take_q      <= 1'b0;
         out_valid_q <= 1'b0;
         root_q      <= '0;
         rem_q       <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         q_q         <= q_d;
         acc_q       <= acc_d;
         s_q         <= s_d;
         mode_q      <= mode_d;
         take_q      <= take_d;
         out_valid_q <= out_valid_d;
         root_q      <= root_d;
         rem_q       <= rem_d;
      end
   end

   // Next state and adder steering: one adder operation per state, idle adder reads zero.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      q_d         = q_q;
      acc_d       = acc_q;
      s_d         = s_q;
      mode_d      = mode_q;
      take_d      = take_q;
      out_valid_d = out_valid_q;
      root_d      = root_q;
      rem_d       = rem_q;
      sum_a       = '0;
      sum_b       = '0;
      sum_cin     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (io.in_valid) begin
               x_d     = AW'(io.x_i);
               y_d     = '0;
               q_d     = '0;
               take_d  = 1'b0;
               mode_d  = io.mode_i;
               s_d     = io.mode_i ? SW'(2 * (ITS - 1)) : SW'(3 * (ITC - 1));
               state_d = S_DBL;
            end
         end
         S_DBL: begin
            y_d     = y_q << 1;
            q_d     = q_q << 2;
            take_d  = 1'b0;
            state_d = mode_q ? S_CMP : S_C3Q;
         end
         S_C3Q: begin
            sum_a   = q_q;
            sum_b   = q_q << 1;
            acc_d   = io.sum_out;
            state_d = S_C3Y2;
         end
         S_C3Y2: begin
            sum_a   = acc_q;
            sum_b   = y_q << 1;
            acc_d   = io.sum_out;
            state_d = S_C3Y1;
         end
         S_C3Y1: begin
            sum_a   = acc_q;
            sum_b   = y_q;
            sum_cin = 1'b1;
            acc_d   = io.sum_out;
            state_d = S_CMP;
         end
         S_CMP: begin
            // x - (delta << s) as x + ~(delta << s) + 1; carry-out means no borrow
            sum_a   = x_q;
            sum_b   = mode_q ? ~(((y_q << 1) | ONE) << s_q) : ~(acc_q << s_q);
            sum_cin = 1'b1;
            if (io.sum_cout) begin
               x_d    = io.sum_out;
               take_d = 1'b1;
               y_d    = y_q | ONE;
            end
            if (!mode_q) begin
               state_d = S_QUPD;
            end else if (s_q == '0) begin
               state_d = S_DONE;
            end else begin
               s_d     = s_q - SW'(2);
               state_d = S_DBL;
            end
         end
         S_QUPD: begin
            // (y+1)^2 = y^2 + 2y + 1, using the even y from before the digit was set
            if (take_q) begin
               sum_a   = q_q;
               sum_b   = (y_q & ~ONE) << 1;
               sum_cin = 1'b1;
               q_d     = io.sum_out;
            end
            if (s_q == '0) begin
               state_d = S_DONE;
            end else begin
               s_d     = s_q - SW'(3);
               state_d = S_DBL;
            end
         end
         S_DONE: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               root_d      = y_q[RW-1:0];
               rem_d       = x_q[WIDTH-1:0];
            end else if (io.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign io.in_ready  = (state_q == S_IDLE);
   assign io.busy      = (state_q != S_IDLE);
   assign io.out_valid = out_valid_q;
   assign io.root_o    = root_q;
   assign io.rem_o     = rem_q;
   assign io.sum_a     = sum_a;
   assign io.sum_b     = sum_b;
   assign io.sum_cin   = sum_cin;
endmodule

// File: tb/tb_root_seq.sv
// Bench for root_seq: 8-bit and 16-bit instances, each with its own behavioural adder.
module tb_root_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   root_seq_if #(.WIDTH(8))  io8 ();
   root_seq_if #(.WIDTH(16)) io16 ();

   assign {io8.sum_cout, io8.sum_out} =
      {1'b0, io8.sum_a} + {1'b0, io8.sum_b} + 13'(io8.sum_cin);
   assign {io16.sum_cout, io16.sum_out} =
      {1'b0, io16.sum_a} + {1'b0, io16.sum_b} + 21'(io16.sum_cin);

   root_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .io(io8.slave));
   root_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .io(io16.slave));

   // floor root by counting up: largest r with r^k <= x
   function automatic int ref_root(input int x, input bit m);
      int r = 0;
      if (m) while ((r + 1) * (r + 1) <= x) r++;
      else   while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   function automatic int ref_rem(input int x, input bit m);
      int r = ref_root(x, m);
      return m ? x - r * r : x - r * r * r;
   endfunction

   // Start one op on the 8-bit unit and wait for out_valid (no handshake).
   // lat = edges from accept to out_valid high, -1 on timeout.
   task automatic op8(input int x, input bit m, input bit rdy, input bit junk,
                      output int r, output int rm, output int lat, output int bad_rdy);
      int w = 0;
      @(negedge clk);
      while (!io8.in_ready && w < 100) begin @(negedge clk); w++; end
      io8.x_i = x[7:0]; io8.mode_i = m; io8.in_valid = 1'b1; io8.out_ready = rdy;
      @(posedge clk);
      #1;
      io8.in_valid = junk; io8.x_i = 8'($urandom); io8.mode_i = 1'($urandom);
      lat = 0; bad_rdy = 0;
      while (lat < 200) begin
         if (io8.in_ready) bad_rdy++;
         @(posedge clk); #1; lat++;
         if (junk) io8.x_i = 8'($urandom);
         if (io8.out_valid) break;
      end
      if (!io8.out_valid) lat = -1;
      r = int'(io8.root_o); rm = int'(io8.rem_o);
   endtask

   task automatic finish8();
      @(negedge clk);
      io8.in_valid = 1'b0; io8.out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic op16(input int x, input bit m, output int r, output int rm, output int lat);
      int w = 0;
      @(negedge clk);
      while (!io16.in_ready && w < 100) begin @(negedge clk); w++; end
      io16.x_i = x[15:0]; io16.mode_i = m; io16.in_valid = 1'b1; io16.out_ready = 1'b1;
      @(posedge clk); #1;
      io16.in_valid = 1'b0; io16.x_i = 16'($urandom); io16.mode_i = 1'($urandom);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); #1; lat++;
         if (io16.out_valid) break;
      end
      if (!io16.out_valid) lat = -1;
      r = int'(io16.root_o); rm = int'(io16.rem_o);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (io8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", io8.out_valid); end
      n_tests++; if (io8.root_o !== 4'd0) begin n_fail++; $display("FAIL reset_root: got %0d want 0", io8.root_o); end
      n_tests++; if (io8.rem_o !== 8'd0) begin n_fail++; $display("FAIL reset_rem: got %0d want 0", io8.rem_o); end
      n_tests++; if (io8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", io8.in_ready); end
      n_tests++; if (io8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", io8.busy); end
      n_tests++; if ({io8.sum_a, io8.sum_b, io8.sum_cin} !== 25'd0) begin n_fail++; $display("FAIL reset_adder_idle: got %h want 0", {io8.sum_a, io8.sum_b, io8.sum_cin}); end
      n_tests++; if (io16.out_valid !== 1'b0 || io16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_w16: got ov=%b ir=%b want 0/1", io16.out_valid, io16.in_ready); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_vectors();
      int xs[7]  = '{27, 255, 255, 0, 0, 1, 1};
      bit ms[7]  = '{0, 0, 1, 0, 1, 0, 1};
      int er[7]  = '{3, 6, 15, 0, 0, 1, 1};
      int erm[7] = '{0, 39, 30, 0, 0, 0, 0};
      int el[7]  = '{19, 19, 9, 19, 9, 19, 9};
      int r, rm, lat, bad;
      for (int i = 0; i < 7; i++) begin
         op8(xs[i], ms[i], 1'b1, 1'b0, r, rm, lat, bad);
         n_tests++; if (r !== er[i]) begin n_fail++; $display("FAIL vec_root x=%0d m=%0d: got %0d want %0d", xs[i], ms[i], r, er[i]); end
         n_tests++; if (rm !== erm[i]) begin n_fail++; $display("FAIL vec_rem x=%0d m=%0d: got %0d want %0d", xs[i], ms[i], rm, erm[i]); end
         n_tests++; if (lat !== el[i]) begin n_fail++; $display("FAIL vec_latency x=%0d m=%0d: got %0d want %0d", xs[i], ms[i], lat, el[i]); end
         finish8();
         n_tests++; if (io8.out_valid !== 1'b0) begin n_fail++; $display("FAIL vec_pulse x=%0d: out_valid got %b want 0", xs[i], io8.out_valid); end
      end
   endtask

   task automatic test_sweep();
      int r, rm, lat, bad, el;
      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 256; x++) begin
            el = (m != 0) ? 2 * ((8 + 1) / 2) + 1 : 6 * ((8 + 2) / 3) + 1;
            op8(x, m[0], 1'($urandom), 1'b0, r, rm, lat, bad);
            n_tests++; if (r !== ref_root(x, m[0]) || rm !== ref_rem(x, m[0])) begin
               n_fail++; $display("FAIL sweep x=%0d m=%0d: got %0d r%0d want %0d r%0d", x, m, r, rm, ref_root(x, m[0]), ref_rem(x, m[0]));
            end
            n_tests++; if (lat !== el) begin n_fail++; $display("FAIL sweep_latency x=%0d m=%0d: got %0d want %0d", x, m, lat, el); end
            finish8();
         end
      end
   endtask

   task automatic test_hold();
      int r, rm, lat, bad, x;
      x = $urandom_range(0, 255);
      op8(x, 1'b0, 1'b0, 1'b1, r, rm, lat, bad);
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL hold_in_ready_busy: got %0d ready cycles want 0", bad); end
      n_tests++; if (r !== ref_root(x, 1'b0) || rm !== ref_rem(x, 1'b0)) begin n_fail++; $display("FAIL hold_result x=%0d: got %0d r%0d want %0d r%0d", x, r, rm, ref_root(x, 1'b0), ref_rem(x, 1'b0)); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         io8.x_i = 8'($urandom); io8.mode_i = 1'($urandom);
         n_tests++; if (io8.out_valid !== 1'b1 || int'(io8.root_o) !== r || int'(io8.rem_o) !== rm || io8.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold_stable cycle %0d: got ov=%b root=%0d rem=%0d ir=%b want 1/%0d/%0d/0", i, io8.out_valid, io8.root_o, io8.rem_o, io8.in_ready, r, rm);
         end
      end
      finish8();
      n_tests++; if (io8.out_valid !== 1'b0 || io8.in_ready !== 1'b1 || io8.busy !== 1'b0) begin
         n_fail++; $display("FAIL hold_release: got ov=%b ir=%b busy=%b want 0/1/0", io8.out_valid, io8.in_ready, io8.busy);
      end
   endtask

   task automatic test_reset_abort();
      int r, rm, lat, bad, seen;
      @(negedge clk);
      io8.x_i = 8'd200; io8.mode_i = 1'b0; io8.in_valid = 1'b1; io8.out_ready = 1'b1;
      @(posedge clk); #1;
      io8.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1; rst = 1'b1; #1;
      n_tests++; if (io8.in_ready !== 1'b1 || io8.out_valid !== 1'b0 || io8.busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_state: got ir=%b ov=%b busy=%b want 1/0/0", io8.in_ready, io8.out_valid, io8.busy);
      end
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (25) begin @(posedge clk); #1; if (io8.out_valid) seen++; end
      n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
      op8(64, 1'b0, 1'b1, 1'b0, r, rm, lat, bad);
      n_tests++; if (r !== 4 || rm !== 0) begin n_fail++; $display("FAIL abort_then_64: got %0d r%0d want 4 r0", r, rm); end
      finish8();
   endtask

   task automatic test_wide();
      int r, rm, lat, x;
      op16(65535, 1'b0, r, rm, lat);
      n_tests++; if (r !== 40 || rm !== 1535 || lat !== 37) begin n_fail++; $display("FAIL wide_cube_max: got %0d r%0d lat %0d want 40 r1535 lat 37", r, rm, lat); end
      op16(65535, 1'b1, r, rm, lat);
      n_tests++; if (r !== 255 || rm !== 510 || lat !== 17) begin n_fail++; $display("FAIL wide_sqrt_max: got %0d r%0d lat %0d want 255 r510 lat 17", r, rm, lat); end
      for (int i = 0; i < 20; i++) begin
         x = $urandom_range(0, 65535);
         op16(x, i[0], r, rm, lat);
         n_tests++; if (r !== ref_root(x, i[0]) || rm !== ref_rem(x, i[0])) begin
            n_fail++; $display("FAIL wide_rand x=%0d m=%0d: got %0d r%0d want %0d r%0d", x, i[0], r, rm, ref_root(x, i[0]), ref_rem(x, i[0]));
         end
      end
   endtask

   task automatic test_back_to_back();
      int xs[8];
      bit ms[8];
      int w, lat, acc_cyc, prev_cyc, prev_lat;
      for (int i = 0; i < 8; i++) begin xs[i] = $urandom_range(0, 255); ms[i] = 1'($urandom); end
      prev_cyc = 0; prev_lat = 0;
      @(negedge clk);
      io8.out_ready = 1'b1; io8.x_i = xs[0][7:0]; io8.mode_i = ms[0]; io8.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         w = 0;
         while (!io8.in_ready && w < 100) begin @(negedge clk); w++; end
         @(posedge clk); #1;
         acc_cyc = cyc;
         if (i > 0) begin
            n_tests++; if (acc_cyc - prev_cyc !== prev_lat + 2) begin
               n_fail++; $display("FAIL b2b_spacing op %0d: got %0d cycles want %0d", i, acc_cyc - prev_cyc, prev_lat + 2);
            end
         end
         if (i < 7) begin io8.x_i = xs[i+1][7:0]; io8.mode_i = ms[i+1]; end
         else io8.in_valid = 1'b0;
         lat = 0;
         while (lat < 200) begin
            @(posedge clk); #1; lat++;
            if (io8.out_valid) break;
         end
         n_tests++; if (!io8.out_valid || int'(io8.root_o) !== ref_root(xs[i], ms[i]) || int'(io8.rem_o) !== ref_rem(xs[i], ms[i])) begin
            n_fail++; $display("FAIL b2b_result op %0d x=%0d m=%0d: got ov=%b %0d r%0d want %0d r%0d", i, xs[i], ms[i], io8.out_valid, io8.root_o, io8.rem_o, ref_root(xs[i], ms[i]), ref_rem(xs[i], ms[i]));
         end
         prev_cyc = acc_cyc;
         prev_lat = ms[i] ? 9 : 19;
      end
      finish8();
   endtask

   initial begin
      io8.in_valid = 1'b0; io8.x_i = '0; io8.mode_i = 1'b0; io8.out_ready = 1'b0;
      io16.in_valid = 1'b0; io16.x_i = '0; io16.mode_i = 1'b0; io16.out_ready = 1'b0;
      test_reset();
      test_vectors();
      test_sweep();
      test_hold();
      test_reset_abort();
      test_wide();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
